wd16_sequencer: RTL and testbench
=================================

Name: wd16_sequencer

Overview:
- Sequences one shared, registered S-box/linear mixing stage (existing `mix_func`: 1-cycle registered S-box layer, combinational `L(y) = y ^ rotl6(y) ^ rotl10(y)`) through `NUM_ROUNDS` keyed rounds.
- Implements the Hummingbird-2 WD16 function: `res = f(...f(f(x^K1)^K2)...^Kn)`.
- Sits between the cipher round controller and the mixing datapath.
- Valid/ready on both sides; one operation in flight.

Parameters:
- `NUM_ROUNDS`, 4, keyed mix rounds per operation; legal range 1..4.
- `CNT_W`, 2, round counter width; holds `NUM_ROUNDS-1`.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request.
- `x_in`  in  16  WD16 data word.
- `key_in`  in  16*NUM_ROUNDS  round keys; `key_in[16r+15:16r]` = K(r+1).
- `abort`  in  1  synchronous cancel.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `out_word`  out  16  WD16 result.
- `busy`  out  1  high in RUN or CAPT.

Behaviour:
- Reset (`rst`=0, async): state=IDLE, `in_ready`=1, `out_valid`=0, `out_word`=0, `busy`=0, round counter=0, `x_reg`/`key_reg`=0.
- The `mix_func` instance resets via `~rst`.
- States: IDLE, RUN, CAPT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid` at an edge: latch `x_in` into `x_reg` and `key_in` into `key_reg`, set rnd=0, go to RUN.
  - `in_valid` without a handshake is ignored.
- RUN:
  - Mix input = (rnd==0 ? `x_reg` : mixed_word) ^ `key_reg`[rnd].
  - Each edge the mixer registers that round; rnd increments.
  - When rnd==NUM_ROUNDS-1 at the edge, go to CAPT.
  - `in_ready`=0.
- CAPT:
  - mixed_word holds the final round output.
  - At the edge: `out_word` <= mixed_word, `out_valid` <= 1, go to DONE.
- DONE:
  - `out_valid`=1; `out_word` is stable until the handshake.
  - On `out_ready`: `out_valid` <= 0, go to IDLE.
  - `out_word` retains its last value after the handshake.
- Latency:
  - Accepting edge E0; `out_valid` rises after edge E(NUM_ROUNDS+1). For the default, `out_valid` is high in the 6th cycle after the accept.
  - Minimum repeat interval is NUM_ROUNDS+3 cycles; there is no accept in DONE even if `out_ready`=1.
- Mix input in IDLE/CAPT/DONE is driven to 0.
- `abort`:
  - In RUN or CAPT: go to IDLE next edge; `out_valid` stays 0; the in-flight result is discarded.
  - In DONE: `abort` has priority over `out_ready`; clears `out_valid`.
  - In IDLE: `abort` has priority over `in_valid`; no accept that cycle.
- Async reset mid-operation: immediate return to reset values; no partial result is ever presented.
- `key_in`/`x_in` changes after the accept have no effect (registered).
- All XOR/rotate arithmetic is 16-bit, with no carries.

Decomposition:
- Shared package `hb2_pkg`:
  - state encoding (IDLE=0, RUN=1, CAPT=2, DONE=3).
  - `WD16_ROUNDS`=4.
  - word width 16.
- Sub-module: existing `mix_func`, one instance.
- Controller FSM, counter and key mux stay in `wd16_sequencer`.

Test Plan:
- Keys all 0, `x_in`=0x0000 -> `out_word`=0xA8AE; `out_valid` rises exactly 5 edges after the accept edge. Intermediate mixed_word values are 0xC222, 0x2592, 0x1940, 0xA8AE.
- `x_in`=0x1234, K1=0x1234, K2..K4=0 -> 0xA8AE (checks the round-0 key XOR).
- `x_in`=0, K1=0, K2=0xC222, K3=K4=0 -> 0x1940 (checks the per-round key index).
- `NUM_ROUNDS`=1, `x_in`=0, K1=0 -> 0xC222 after 2 edges.
- Hold `out_ready`=0 for 10 cycles in DONE with a new `in_valid` pending -> `out_word` stable, `in_ready`=0. Release -> one IDLE cycle, then the next request is accepted.
- `abort` on the RUN cycle with rnd=2 -> IDLE next edge, `out_valid` never asserts, next request gives the correct result. Async `rst` pulse mid-RUN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/hb2_pkg.sv
// hb2_pkg: shared Hummingbird-2 WD16 types, constants and mixing helpers.
package hb2_pkg;
  localparam int WORD_W      = 16;
  localparam int WD16_ROUNDS = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    CAPT = 2'd2,
    DONE = 2'd3
  } state_e;
  // Each table packs entry i into bits [4i+3:4i].
  localparam logic [63:0] SBOX1 = 64'h3A84_0D6B_F512_9EC7;
  localparam logic [63:0] SBOX2 = 64'h2B95_DE03_C7F8_61A4;
  localparam logic [63:0] SBOX3 = 64'h79B0_438E_DA65_1CF2;
  localparam logic [63:0] SBOX4 = 64'hBDC6_E03A_1279_854F;
  function automatic logic [WORD_W-1:0] sbox16(input logic [WORD_W-1:0] x);
    return {SBOX1[{x[15:12], 2'b00} +: 4], SBOX2[{x[11:8], 2'b00} +: 4],
            SBOX3[{x[7:4], 2'b00} +: 4], SBOX4[{x[3:0], 2'b00} +: 4]};
  endfunction
  function automatic logic [WORD_W-1:0] lin16(input logic [WORD_W-1:0] y);
    return y ^ {y[9:0], y[15:10]} ^ {y[5:0], y[15:6]};
  endfunction
endpackage

// File: rtl/mix_func.sv
// mix_func: registered 4x4-bit S-box layer followed by the combinational WD16 linear map.
//   clk     in   clock, rising edge
//   rst     in   asynchronous reset, active-high
//   mix_in  in   16-bit word to substitute
//   mix_out out  L(S(mix_in)) as registered on the last edge
module mix_func
  import hb2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] mix_in,
  output logic [WORD_W-1:0] mix_out
);
  logic [WORD_W-1:0] s_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) s_q <= '0;
    else     s_q <= sbox16(mix_in);
  assign mix_out = lin16(s_q);
endmodule

// File: rtl/wd16_sequencer.sv
// wd16_sequencer: runs the shared mix_func stage through NUM_ROUNDS keyed WD16 rounds.
//   clk/rst          clock; asynchronous active-low reset
//   in_valid/ready   request handshake carrying x_in and key_in (K(r+1) at [16r+15:16r])
//   abort            synchronous cancel of a pending or presented operation
//   out_valid/ready  result handshake carrying out_word
//   busy             high while rounds are running or the result is being captured
module wd16_sequencer
  import hb2_pkg::*;
#(
  parameter int NUM_ROUNDS = WD16_ROUNDS,
  parameter int CNT_W      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WORD_W-1:0]            x_in,
  input  logic [WORD_W*NUM_ROUNDS-1:0] key_in,
  input  logic                         abort,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORD_W-1:0]            out_word,
  output logic                         busy
);
  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             rnd_q, rnd_d;
  logic [WORD_W-1:0]            x_q, x_d;
  logic [WORD_W*NUM_ROUNDS-1:0] key_q, key_d;
  logic [WORD_W-1:0]            out_word_q, out_word_d;
  logic                         out_valid_q, out_valid_d;
  logic [WORD_W-1:0]            mix_in, mixed_word;
  logic                         last_rnd;
  assign last_rnd = rnd_q == CNT_W'(NUM_ROUNDS - 1);
  always_comb begin
    state_d     = state_q;
    rnd_d       = rnd_q;
    x_d         = x_q;
    key_d       = key_q;
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q;
    mix_in      = '0;
    case (state_q)
      IDLE:
        if (!abort && in_valid) begin
          x_d     = x_in;
          key_d   = key_in;
          rnd_d   = '0;
          state_d = RUN;
        end
      RUN: begin
        // Round 0 starts from the latched word; later rounds chain the mixer output.
        mix_in  = (rnd_q == '0 ? x_q : mixed_word) ^ key_q[rnd_q*WORD_W +: WORD_W];
        rnd_d   = rnd_q + CNT_W'(1);
        state_d = abort ? IDLE : last_rnd ? CAPT : RUN;
      end
      CAPT:
        if (abort) state_d = IDLE;
        else begin
          out_word_d  = mixed_word;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      DONE:
        if (abort || out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q     <= IDLE;
      rnd_q       <= '0;
      x_q         <= '0;
      key_q       <= '0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rnd_q       <= rnd_d;
      x_q         <= x_d;
      key_q       <= key_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
    end
  mix_func u_mix (
    .clk    (clk),
    .rst    (~rst),
    .mix_in (mix_in),
    .mix_out(mixed_word)
  );
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q == RUN || state_q == CAPT;
  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
endmodule

// File: tb/tb_wd16_sequencer.sv
// tb_wd16_sequencer: random and directed checks of wd16_sequencer against a WD16 reference model.
module tb_wd16_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_ready, abort = 1'b0, out_valid, out_ready = 1'b0, busy;
  logic [15:0] x_in = '0, out_word;
  logic [63:0] key_in = '0;
  logic        n1_in_valid = 1'b0, n1_in_ready, n1_out_valid, n1_out_ready = 1'b0, n1_busy;
  logic [15:0] n1_x_in = '0, n1_key_in = '0, n1_out_word;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  wd16_sequencer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .key_in(key_in), .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .busy(busy)
  );

  wd16_sequencer #(.NUM_ROUNDS(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(n1_in_valid), .in_ready(n1_in_ready), .x_in(n1_x_in),
    .key_in(n1_key_in), .abort(1'b0), .out_valid(n1_out_valid), .out_ready(n1_out_ready),
    .out_word(n1_out_word), .busy(n1_busy)
  );

  int s1[16] = '{7, 12, 14, 9, 2, 1, 5, 15, 11, 6, 13, 0, 4, 8, 10, 3};
  int s2[16] = '{4, 10, 1, 6, 8, 15, 7, 12, 3, 0, 14, 13, 5, 9, 11, 2};
  int s3[16] = '{2, 15, 12, 1, 5, 6, 10, 13, 14, 8, 3, 4, 0, 11, 9, 7};
  int s4[16] = '{15, 4, 5, 8, 9, 7, 2, 1, 10, 3, 0, 14, 6, 12, 13, 11};

  function automatic logic [15:0] rotl(input logic [15:0] v, input int n);
    return (v << n) | (v >> (16 - n));
  endfunction

  function automatic logic [15:0] wd_f(input logic [15:0] v);
    logic [15:0] y;
    y = {4'(s1[v[15:12]]), 4'(s2[v[11:8]]), 4'(s3[v[7:4]]), 4'(s4[v[3:0]])};
    return y ^ rotl(y, 6) ^ rotl(y, 10);
  endfunction

  function automatic logic [15:0] model(input logic [15:0] x, input logic [63:0] k, input int r);
    logic [15:0] v = x;
    for (int i = 0; i < r; i++) v = wd_f(v ^ k[16*i +: 16]);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] x, input logic [63:0] k);
    in_valid = 1'b1;
    x_in = x;
    key_in = k;
    tick();
    chk("accept_busy", busy, 1);
    in_valid = 1'b0;
    x_in = 16'($urandom);
    key_in = {$urandom, $urandom};
  endtask

  task automatic wait_res(input logic [15:0] x, input logic [63:0] k);
    int cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
      if (cnt <= 4) chk($sformatf("round%0d_word", cnt), dut.mixed_word, model(x, k, cnt));
    end
    chk("latency", cnt, 5);
    chk("result", out_word, model(x, k, 4));
  endtask

  task automatic finish_hs(input int hold);
    logic [15:0] w = out_word;
    repeat (hold) begin
      tick();
      chk("hold_stable", {out_valid, in_ready, out_word}, {1'b1, 1'b0, w});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("after_hs", {out_valid, in_ready, busy, out_word}, {1'b1, 1'b0, 1'b0, w} ^ 19'h60000);
  endtask

  initial begin
    logic [15:0] x, x2;
    logic [63:0] k, k2;
    int cnt;
    bit seen;
    #1;
    chk("reset_state", {in_ready, out_valid, busy, out_word}, {1'b1, 1'b0, 1'b0, 16'h0000});
    tick();
    tick();
    rst = 1'b1;
    tick();
    start(16'h0000, 64'h0);
    wait_res(16'h0000, 64'h0);
    chk("vec_zero", out_word, 16'hA8AE);
    finish_hs(0);
    start(16'h1234, 64'h0000_0000_0000_1234);
    wait_res(16'h1234, 64'h0000_0000_0000_1234);
    chk("vec_k1", out_word, 16'hA8AE);
    finish_hs(1);
    start(16'h0000, 64'h0000_0000_C222_0000);
    wait_res(16'h0000, 64'h0000_0000_C222_0000);
    chk("vec_k2", out_word, 16'h1940);
    finish_hs(2);
    for (int i = 0; i < 25; i++) begin
      x = 16'($urandom);
      k = {$urandom, $urandom};
      start(x, k);
      wait_res(x, k);
      finish_hs(int'($urandom_range(0, 3)));
    end
    // A second request waits on in_valid while the result is held back.
    x = 16'($urandom); k = {$urandom, $urandom};
    x2 = 16'($urandom); k2 = {$urandom, $urandom};
    start(x, k);
    in_valid = 1'b1; x_in = x2; key_in = k2;
    wait_res(x, k);
    finish_hs(10);
    tick();
    chk("accept_after_idle", busy, 1);
    in_valid = 1'b0;
    wait_res(x2, k2);
    finish_hs(0);
    // Abort on the round-2 cycle.
    x = 16'($urandom); k = {$urandom, $urandom};
    start(x, k);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_run_idle", {busy, in_ready, out_valid}, 3'b010);
    seen = 1'b0;
    repeat (8) begin
      tick();
      seen |= out_valid;
    end
    chk("abort_no_valid", seen, 0);
    x = 16'($urandom); k = {$urandom, $urandom};
    start(x, k);
    wait_res(x, k);
    // Abort wins over out_ready in DONE.
    abort = 1'b1;
    out_ready = 1'b1;
    tick();
    abort = 1'b0;
    out_ready = 1'b0;
    chk("abort_done", {out_valid, in_ready}, 2'b01);
    // Abort wins over in_valid in IDLE.
    abort = 1'b1;
    in_valid = 1'b1;
    tick();
    abort = 1'b0;
    in_valid = 1'b0;
    chk("abort_idle", {busy, in_ready}, 2'b01);
    // Asynchronous reset mid-run.
    x = 16'($urandom); k = {$urandom, $urandom};
    start(x, k);
    tick();
    rst = 1'b0;
    #1;
    chk("async_rst", {in_ready, out_valid, busy, out_word}, {1'b1, 1'b0, 1'b0, 16'h0000});
    tick();
    rst = 1'b1;
    tick();
    x = 16'($urandom); k = {$urandom, $urandom};
    start(x, k);
    wait_res(x, k);
    finish_hs(0);
    // Single-round instance.
    for (int i = 0; i < 4; i++) begin
      x = i == 0 ? 16'h0000 : 16'($urandom);
      k = i == 0 ? 64'h0 : {48'h0, 16'($urandom)};
      n1_in_valid = 1'b1;
      n1_x_in = x;
      n1_key_in = k[15:0];
      tick();
      n1_in_valid = 1'b0;
      cnt = 0;
      while (!n1_out_valid && cnt < 10) begin
        tick();
        cnt++;
      end
      chk("n1_latency", cnt, 2);
      chk("n1_result", n1_out_word, i == 0 ? 16'hC222 : model(x, k, 1));
      n1_out_ready = 1'b1;
      tick();
      n1_out_ready = 1'b0;
      chk("n1_after_hs", {n1_out_valid, n1_in_ready}, 2'b01);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout after %0d checks", n_chk);
    $fatal(1, "timeout");
  end
endmodule
